counter_step_ctrl: RTL and testbench
====================================

Name: counter_step_ctrl

Overview:
Upstream control stage for the up/down counter. It turns two raw pushbuttons (up, down) into the counter's en and up_down inputs. Each button is synchronised and debounced. A press produces exactly one single-cycle en pulse with up_down set to the direction. A long hold optionally auto-repeats. The en and up_down outputs connect directly to the counter's en and up_down ports, and both blocks share clk and rst.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised input must differ from the debounced level before that level flips (>=1)
REPEAT_DELAY, 16, cycles from first pulse to first auto-repeat pulse (>=2)
REPEAT_RATE, 4, cycles between auto-repeat pulses after the first (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
btn_up  input  1  raw up button, asynchronous, active-high
btn_dn  input  1  raw down button, asynchronous, active-high
hold  input  1  synchronous inhibit; while 1, no en pulses
en  output  1  single-cycle step pulse to counter
up_down  output  1  direction to counter, 1=up, 0=down
repeat_active  output  1  1 while FSM is in REPEAT

Behaviour:
- Reset, sampled on clk rising edge when rst=1: en=0, up_down=1, repeat_active=0, synchronisers=0, debounced levels=0, debounce counters=0, timer=0, FSM=IDLE.
- Synchroniser: 2 flops per button (s1, s2).
- Debouncer, per button:
  - Counter increments each cycle that s2 != deb, and clears when they match.
  - deb flips on the edge where the counter would reach DEBOUNCE_CYCLES; the counter clears on that edge.
  - A glitch shorter than DEBOUNCE_CYCLES never changes deb.
- Press event: deb rising (deb=1 and previous deb=0), registered internally.
- All outputs are registered.
- en is high for exactly one cycle per step.
- up_down is updated on the same edge as the en pulse and holds its value afterwards. It never changes while en=0, except at reset.
- Latency: if raw btn is first sampled high at edge k, deb goes high after edge k+1+D and en=1 after edge k+2+D (D=DEBOUNCE_CYCLES).
- FSM states:
  - IDLE:
    - up press only -> pulse en, up_down=1, go HELD, timer=0.
    - dn press only -> pulse en, up_down=0, go HELD, timer=0.
    - Both debounced levels high -> LOCK, no pulse.
    - A level high without a press event (e.g. after hold) -> no action.
  - HELD:
    - Active button deb low -> IDLE.
    - Other button deb high -> LOCK.
    - Timer reaches REPEAT_DELAY -> pulse en, timer=0, go REPEAT.
  - REPEAT:
    - Same exits as HELD.
    - Pulse en every REPEAT_RATE cycles; repeat_active=1.
  - LOCK: no pulses; -> IDLE only when both deb levels are 0.
- hold=1:
  - Forces FSM to IDLE on the next edge and en=0; up_down is unchanged.
  - Debouncers keep running.
  - A button still held when hold drops gives no pulse until it is released and pressed again.
- Pulses already due while deb is still high during the release debounce window are issued. This is accepted behaviour.
- Reset mid-operation: immediate return to reset values. A button still physically held after reset debounces as a fresh press and pulses D+2 edges after rst falls.
- Timer width: ceil(log2(max(REPEAT_DELAY, REPEAT_RATE)+1)). The timer saturates and never wraps.

Optional Feature:
AUTO_REPEAT_EN
- Defined: HELD/REPEAT auto-repeat as above.
- Undefined:
  - The timer, the REPEAT state and the repeat logic are not compiled.
  - HELD waits indefinitely for release or LOCK, so there is exactly one pulse per press.
  - repeat_active is tied to 0.

Test Plan:
1. rst=1 for 2 cycles with buttons low -> en=0, up_down=1, repeat_active=0; all hold with no stimulus for 20 cycles.
2. btn_up high for 3 cycles, then low (D=4) -> en stays 0, up_down stays 1.
3. Without AUTO_REPEAT_EN: btn_dn high edges 0-29 -> exactly one en pulse after edge 6 with up_down=0; up_down remains 0 afterwards.
4. AUTO_REPEAT_EN, defaults: btn_up high edges 0-39 -> en pulses after edges 6, 22, 26, 30, 34, 38, 42 (7 total); repeat_active=1 from edge 22 until edge 46.
5. btn_up and btn_dn raised on the same edge -> no pulse (LOCK). Drop btn_up -> still none. Drop btn_dn, then press btn_dn -> one pulse, up_down=0.
6. In REPEAT, assert hold -> en=0 from the next edge, repeat_active=0. Release hold with the button still held -> no pulse. Then assert rst -> up_down=1.

Source files
------------

// File: rtl/counter_step_ctrl.sv
// Pushbutton front end for the up/down counter: synchronise, debounce and turn presses into
// single-cycle step pulses. Define AUTO_REPEAT_EN to compile the hold-to-repeat logic.
module counter_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_RATE     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic hold,
    output logic en,
    output logic up_down,
    output logic repeat_active
);

    localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_check
        $error("counter_step_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StLock
`ifdef AUTO_REPEAT_EN
        ,
        StRepeat
`endif
    } state_e;

    // Bit 1 is the up button, bit 0 the down button.
    logic [1:0]     s1_q, s2_q;
    logic [1:0]     deb_q, deb_d;
    logic [1:0]     deb_prev_q;
    logic [DCW-1:0] cnt_q [2];
    logic [DCW-1:0] cnt_d [2];
    logic [1:0]     press;

    state_e state_q, state_d;
    logic   en_q, en_d;
    logic   up_down_q, up_down_d;
    logic   active_deb, other_deb;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned TIMER_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TW        = $clog2(TIMER_MAX + 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_inc;
    logic          repeat_q, repeat_d;

    assign timer_inc = (timer_q == TW'(TIMER_MAX)) ? timer_q : timer_q + 1'b1;
`endif

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press      = deb_q & ~deb_prev_q;
    assign active_deb = up_down_q ? deb_q[1] : deb_q[0];
    assign other_deb  = up_down_q ? deb_q[0] : deb_q[1];

    always_comb begin
        state_d   = state_q;
        en_d      = 1'b0;
        up_down_d = up_down_q;
`ifdef AUTO_REPEAT_EN
        timer_d   = timer_q;
`endif
        case (state_q)
            StIdle: begin
                if (&deb_q) begin
                    state_d = StLock;
                end else if (press[1]) begin
                    en_d      = 1'b1;
                    up_down_d = 1'b1;
                    state_d   = StHeld;
`ifdef AUTO_REPEAT_EN
                    timer_d   = '0;
`endif
                end else if (press[0]) begin
                    en_d      = 1'b1;
                    up_down_d = 1'b0;
                    state_d   = StHeld;
`ifdef AUTO_REPEAT_EN
                    timer_d   = '0;
`endif
                end
            end
            StHeld: begin
                if (!active_deb) begin
                    state_d = StIdle;
                end else if (other_deb) begin
                    state_d = StLock;
`ifdef AUTO_REPEAT_EN
                end else if (timer_q == TW'(REPEAT_DELAY - 1)) begin
                    en_d    = 1'b1;
                    timer_d = '0;
                    state_d = StRepeat;
                end else begin
                    timer_d = timer_inc;
`endif
                end
            end
`ifdef AUTO_REPEAT_EN
            StRepeat: begin
                if (!active_deb) begin
                    state_d = StIdle;
                end else if (other_deb) begin
                    state_d = StLock;
                end else if (timer_q == TW'(REPEAT_RATE - 1)) begin
                    en_d    = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
`endif
            StLock: begin
                if (deb_q == 2'b00) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Inhibit wins over everything; direction is left untouched.
        if (hold) begin
            state_d   = StIdle;
            en_d      = 1'b0;
            up_down_d = up_down_q;
        end
    end

`ifdef AUTO_REPEAT_EN
    assign repeat_d = (state_d == StRepeat);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            state_q    <= StIdle;
            en_q       <= 1'b0;
            up_down_q  <= 1'b1;
`ifdef AUTO_REPEAT_EN
            timer_q    <= '0;
            repeat_q   <= 1'b0;
`endif
        end else begin
            s1_q       <= {btn_up, btn_dn};
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q    <= state_d;
            en_q       <= en_d;
            up_down_q  <= up_down_d;
`ifdef AUTO_REPEAT_EN
            timer_q    <= timer_d;
            repeat_q   <= repeat_d;
`endif
        end
    end

    assign en      = en_q;
    assign up_down = up_down_q;
`ifdef AUTO_REPEAT_EN
    assign repeat_active = repeat_q;
`else
    assign repeat_active = 1'b0;
`endif

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Directed bench for counter_step_ctrl with default parameters (D=4, delay 16, rate 4).
// Expectations follow the AUTO_REPEAT_EN setting the bench is compiled with.
module tb_counter_step_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_up;
    logic btn_dn;
    logic hold;
    logic en;
    logic up_down;
    logic repeat_active;

    int   checks = 0;
    int   errors = 0;
    logic exp_ud;
    logic exp_en;
    logic exp_ra;

    always #5 clk = ~clk;

    counter_step_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up       (btn_up),
        .btn_dn       (btn_dn),
        .hold         (hold),
        .en           (en),
        .up_down      (up_down),
        .repeat_active(repeat_active)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Edge e is the posedge following this call; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input int e);
        check($sformatf("%s_en@%0d", name, e), en, exp_en);
        check($sformatf("%s_ud@%0d", name, e), up_down, exp_ud);
        check($sformatf("%s_ra@%0d", name, e), repeat_active, exp_ra);
    endtask

    task automatic settle(input string name, input int n);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        hold   = 1'b0;
        exp_en = 1'b0;
        exp_ra = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check_outs(name, i);
        end
    endtask

    initial begin
        rst    = 1'b1;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        hold   = 1'b0;
        exp_ud = 1'b1;
        exp_en = 1'b0;
        exp_ra = 1'b0;

        // Reset and quiet idle.
        tick();
        tick();
        check_outs("reset", 0);
        rst = 1'b0;
        settle("idle", 20);

        // Glitch shorter than the debounce window.
        for (int e = 0; e < 20; e++) begin
            btn_up = (e < 3);
            tick();
            check_outs("glitch", e);
        end
        settle("glitch_settle", 5);

`ifdef AUTO_REPEAT_EN
        // Long up hold: first pulse, delay, then repeats until release debounces.
        for (int e = 0; e < 55; e++) begin
            btn_up = (e <= 39);
            exp_en = (e == 6) || (e >= 22 && e <= 42 && ((e - 22) % 4) == 0);
            exp_ra = (e >= 22 && e < 46);
            tick();
            check_outs("repeat", e);
        end
`else
        // Long down hold: exactly one pulse.
        for (int e = 0; e < 50; e++) begin
            btn_dn = (e <= 29);
            exp_en = (e == 6);
            if (e == 6) exp_ud = 1'b0;
            tick();
            check_outs("single", e);
        end
`endif
        settle("hold_settle", 5);

        // Both buttons together lock out; only a fresh press after full release steps.
        for (int e = 0; e <= 70; e++) begin
            btn_up = (e <= 14);
            btn_dn = (e <= 29) || (e >= 45 && e <= 54);
            exp_en = (e == 51);
            if (e == 51) exp_ud = 1'b0;
            tick();
            check_outs("lock", e);
        end
        settle("lock_settle", 5);

        // Inhibit during a long down hold, then reset with the button still held.
        for (int e = 0; e < 50; e++) begin
            btn_dn = 1'b1;
            hold   = (e >= 30 && e <= 35);
`ifdef AUTO_REPEAT_EN
            exp_en = (e == 6) || (e == 22) || (e == 26);
            exp_ra = (e >= 22 && e < 30);
`else
            exp_en = (e == 6);
`endif
            if (e == 6) exp_ud = 1'b0;
            tick();
            check_outs("inhibit", e);
        end
        rst    = 1'b1;
        exp_en = 1'b0;
        exp_ra = 1'b0;
        exp_ud = 1'b1;
        tick();
        tick();
        check_outs("midreset", 0);
        rst = 1'b0;
        for (int e = 0; e < 30; e++) begin
            btn_dn = (e < 10);
            exp_en = (e == 6);
            if (e == 6) exp_ud = 1'b0;
            tick();
            check_outs("after_reset", e);
        end
        settle("final", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
